// File: rtl/aes_pkg.sv
// AES helpers shared by the key schedule and the cipher core:
// key-length modes, Nk/Nr lookup, round constants and the S-box.
package aes_pkg;

  typedef logic [0:31]  word_t;
  typedef logic [0:127] round_key_t;

  typedef enum logic [1:0] {
    KL_128  = 2'd0,
    KL_192  = 2'd1,
    KL_256  = 2'd2,
    KL_256X = 2'd3
  } key_len_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXPAND,
    S_DONE
  } ks_state_e;

  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // One row per high nibble, low nibble selects the byte MSB-first.
  localparam logic [127:0] SBOX [16] = '{
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox_lookup(input logic [7:0] a);
    return SBOX[a[7:4]][{~a[3:0], 3'b000} +: 8];
  endfunction

  function automatic logic [3:0] nk_of(input key_len_e kl);
    logic [3:0] n;
    unique case (kl)
      KL_128:  n = 4'd4;
      KL_192:  n = 4'd6;
      default: n = 4'd8;
    endcase
    return n;
  endfunction

  function automatic logic [3:0] nr_of(input key_len_e kl);
    logic [3:0] n;
    unique case (kl)
      KL_128:  n = 4'd10;
      KL_192:  n = 4'd12;
      default: n = 4'd14;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box byte substitution.
// Shared between the key schedule and the cipher core.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);

  assign dout = sbox_lookup(din);

endmodule

// File: rtl/key_expansion_iter.sv
// Iterative AES-128/192/256 key schedule, one word per cycle.
// Build option AES_KEYEXP_ZEROIZE_EN hides stale key material.
module key_expansion_iter
  import aes_pkg::*;
#(
  parameter int MAX_NK = 8,
  parameter int KEY_W  = 32 * MAX_NK,
  parameter int IDX_W  = 4
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic [0:KEY_W-1] key_i,
  input  logic [1:0]       key_len_i,
  input  logic             key_v_i,
  output logic             key_ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [3:0]       nr_o,
  input  logic [IDX_W-1:0] rk_idx_i,
  output round_key_t       rk_o,
  output logic             rk_valid_o
);

  localparam int NW = 4 * (MAX_NK + 7);
  localparam int CW = $clog2(NW + 1);
  localparam int VW = CW + 1;

  ks_state_e         state_q;
  word_t             w_q [NW];
  logic [CW-1:0]     count_q;
  logic [3:0]        nk_q;
  logic [2:0]        j_q;
  logic [3:0]        rcon_q;

  word_t             prev_w;
  word_t             sub_in;
  word_t             sub_out;
  word_t             t_w;
  logic [3:0]        nk_new;
  logic [3:0]        nr_new;
  logic [CW-1:0]     last_cnt;
  logic [CW-1:0]     base;
  logic [VW-1:0]     need;
  logic              in_range;

  assign nk_new   = nk_of(key_len_e'(key_len_i));
  assign nr_new   = nr_of(key_len_e'(key_len_i));
  assign last_cnt = {nr_o, 2'b00} + CW'(3);
  assign prev_w   = w_q[count_q - CW'(1)];

  assign sub_in = (j_q == 3'd0) ? {prev_w[8:31], prev_w[0:7]}
                                : prev_w;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .din  (sub_in[8*b +: 8]),
      .dout (sub_out[8*b +: 8])
    );
  end

  always_comb begin
    t_w = prev_w;
    unique case (1'b1)
      j_q == 3'd0:
        t_w = sub_out ^ {RCON[rcon_q - 4'd1], 24'h0};
      nk_q == 4'd8 && j_q == 3'd4:
        t_w = sub_out;
      default:
        t_w = prev_w;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      nk_q        <= '0;
      j_q         <= '0;
      rcon_q      <= 4'd1;
      nr_o        <= '0;
      key_ready_o <= 1'b1;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      for (int i = 0; i < NW; i++) w_q[i] <= '0;
    end else begin
      done_o <= 1'b0;
      unique case (state_q)
        S_EXPAND: begin
          w_q[count_q] <= w_q[count_q - CW'(nk_q)] ^ t_w;
          count_q      <= count_q + CW'(1);
          j_q <= ({1'b0, j_q} == nk_q - 4'd1) ? 3'd0
                                              : j_q + 3'd1;
          if (j_q == 3'd0) rcon_q <= rcon_q + 4'd1;
          if (count_q == last_cnt) begin
            state_q     <= S_DONE;
            done_o      <= 1'b1;
            busy_o      <= 1'b0;
            key_ready_o <= 1'b1;
          end
        end
        default: begin
          if (key_v_i) begin
`ifdef AES_KEYEXP_ZEROIZE_EN
            for (int i = 0; i < NW; i++) w_q[i] <= '0;
`endif
            for (int i = 0; i < MAX_NK; i++) begin
              if (i < int'(nk_new)) w_q[i] <= key_i[32*i +: 32];
            end
            nk_q        <= nk_new;
            nr_o        <= nr_new;
            count_q     <= CW'(nk_new);
            j_q         <= '0;
            rcon_q      <= 4'd1;
            state_q     <= S_EXPAND;
            key_ready_o <= 1'b0;
            busy_o      <= 1'b1;
          end
        end
      endcase
    end
  end

  assign base       = {rk_idx_i, 2'b00};
  assign need       = {1'b0, rk_idx_i, 2'b00} + VW'(4);
  assign in_range   = (rk_idx_i <= nr_o);
  assign rk_valid_o = in_range && ({1'b0, count_q} >= need);

  always_comb begin
    rk_o = '0;
    if (in_range) begin
      rk_o = {w_q[base], w_q[base + CW'(1)],
              w_q[base + CW'(2)], w_q[base + CW'(3)]};
    end
`ifdef AES_KEYEXP_ZEROIZE_EN
    if (!rk_valid_o) rk_o = '0;
`endif
  end

endmodule
